clock_domain_ctrl: RTL and testbench

CLOCK_DOMAIN_CTRL -- requirements
Module: clock_domain_ctrl

---
 rtl/clk_domain_pkg.sv | 16 +
 rtl/clk_div_chan.sv | 199 +++++++++++++++++++
 rtl/clock_domain_ctrl.sv | 43 ++++
 tb/tb_clock_domain_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_domain_pkg.sv
// clk_domain_pkg: shared types and limits for the gated clock channels.
// Optional feature macro used by the channel RTL: CLK_DOMAIN_AUTO_GATE_EN.
package clk_domain_pkg;

  // Largest channel count the controller is built for
  localparam int MAX_CH = 16;

  // Per-channel lifecycle of a gated, divided clock
  typedef enum logic [1:0] {
    OFF      = 2'd0,
    STARTING = 2'd1,
    RUN      = 2'd2,
    STOPPING = 2'd3
  } chan_state_e;

endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one gated clock channel. A counter runs 0..D and toggles the
// output at D, so each phase lasts D+1 source cycles. Starts and stops only on
// phase boundaries so no runt pulse is ever produced; new divide values land
// on a full-period boundary (immediately while OFF).
// Optional: CLK_DOMAIN_AUTO_GATE_EN adds idle counting and auto-gating.
module clk_div_chan
  import clk_domain_pkg::*;
#(
  parameter int DIV_W  = 4,
  parameter int IDLE_W = 8
) (
  input  logic              clk_in,
  input  logic              reset_n,
  input  logic              en_req,
  input  logic [DIV_W-1:0]  div_sel,
  input  logic              div_load,
  input  logic              busy,
  input  logic [IDLE_W-1:0] idle_limit,
  output logic              clk_out,
  output logic              en_ack,
  output logic              clk_running
);

  chan_state_e      state_reg, state_next;
  logic [DIV_W-1:0] cnt_reg, cnt_next;
  logic [DIV_W-1:0] d_reg, d_next;
  logic [DIV_W-1:0] pend_val_reg, pend_val_next;
  logic             pend_reg, pend_next;
  logic             clk_reg, clk_next;
  logic             ack_reg, ack_next;
  logic             tick;      // current phase ends on this edge
  logic             boundary;  // point where a pending divide may land
  logic             to_off;    // stop completes on this edge

`ifdef CLK_DOMAIN_AUTO_GATE_EN
  logic              run_reg, run_next;
  logic              gate_reg, gate_next;   // stopped by idleness, grant kept
  logic [IDLE_W-1:0] idle_reg, idle_next;
  logic [IDLE_W:0]   idle_inc;
`endif

  assign tick = (cnt_reg == d_reg);

  // Channel state, divider and divide-value registers
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= OFF;
      cnt_reg      <= '0;
      d_reg        <= '0;
      pend_val_reg <= '0;
      pend_reg     <= 1'b0;
      clk_reg      <= 1'b0;
      ack_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      d_reg        <= d_next;
      pend_val_reg <= pend_val_next;
      pend_reg     <= pend_next;
      clk_reg      <= clk_next;
      ack_reg      <= ack_next;
    end
  end

`ifdef CLK_DOMAIN_AUTO_GATE_EN
  // Auto-gate bookkeeping registers
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      run_reg  <= 1'b0;
      gate_reg <= 1'b0;
      idle_reg <= '0;
    end else begin
      run_reg  <= run_next;
      gate_reg <= gate_next;
      idle_reg <= idle_next;
    end
  end
`endif

  // Next-state, divider stepping and divide-value hand-over
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    clk_next      = clk_reg;
    d_next        = d_reg;
    pend_next     = pend_reg;
    pend_val_next = pend_val_reg;
    ack_next      = ack_reg;
    boundary      = 1'b0;
    to_off        = 1'b0;
`ifdef CLK_DOMAIN_AUTO_GATE_EN
    run_next  = run_reg;
    gate_next = gate_reg;
    idle_next = '0;
    idle_inc  = {1'b0, idle_reg} + 1'b1;
`endif
    if (state_reg == OFF) begin
      cnt_next = '0;
      clk_next = 1'b0;
      if (div_load) begin
        d_next    = div_sel;
        pend_next = 1'b0;
      end
`ifdef CLK_DOMAIN_AUTO_GATE_EN
      if (gate_reg) begin
        if (!en_req) begin
          ack_next  = 1'b0;
          gate_next = 1'b0;
        end else if (busy) begin
          state_next = STARTING;
          gate_next  = 1'b0;
        end
      end else if (en_req) begin
        state_next = STARTING;
      end
`else
      if (en_req) state_next = STARTING;
`endif
    end else begin
      // Divider keeps running in every active state
      if (tick) begin
        cnt_next = '0;
        clk_next = ~clk_reg;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
      if (div_load) begin
        pend_next     = 1'b1;
        pend_val_next = div_sel;
      end
      case (state_reg)
        STARTING: begin
          if (tick) begin
            state_next = RUN;
            ack_next   = 1'b1;
`ifdef CLK_DOMAIN_AUTO_GATE_EN
            run_next   = 1'b1;
`endif
          end
        end
        RUN: begin
          if (!en_req) begin
            state_next = STOPPING;
          end
`ifdef CLK_DOMAIN_AUTO_GATE_EN
          else if (busy) begin
            idle_next = '0;
          end else begin
            idle_next = (&idle_reg) ? idle_reg : idle_reg + 1'b1;
            if ((idle_limit != '0) && (idle_inc >= {1'b0, idle_limit})) begin
              state_next = STOPPING;
              gate_next  = 1'b1;
            end
          end
`endif
        end
        STOPPING: begin
`ifdef CLK_DOMAIN_AUTO_GATE_EN
          if (!en_req) gate_next = 1'b0;
`endif
          // Low phase may be cut short; a high phase always runs to its end
          if (!clk_reg || tick) to_off = 1'b1;
        end
        default: ;
      endcase
      boundary = (tick && clk_reg) || to_off;
      if (boundary) begin
        if (div_load)      d_next = div_sel;
        else if (pend_reg) d_next = pend_val_reg;
        pend_next = 1'b0;
      end
      if (to_off) begin
        state_next = OFF;
        cnt_next   = '0;
        clk_next   = 1'b0;
`ifdef CLK_DOMAIN_AUTO_GATE_EN
        ack_next   = gate_reg && en_req;
        gate_next  = gate_reg && en_req;
        run_next   = 1'b0;
`else
        ack_next   = 1'b0;
`endif
      end
    end
  end

  assign clk_out = clk_reg;
  assign en_ack  = ack_reg;

`ifdef CLK_DOMAIN_AUTO_GATE_EN
  assign clk_running = run_reg;
`else
  // Without auto-gating the clock runs exactly while the grant is held
  assign clk_running = ack_reg;
  logic unused_inputs;
  assign unused_inputs = ^{busy, idle_limit};
`endif

endmodule

// File: rtl/clock_domain_ctrl.sv
// clock_domain_ctrl: NUM_CH independent gated, divided clock channels driven
// from one source clock. Optional macro: CLK_DOMAIN_AUTO_GATE_EN.
module clock_domain_ctrl
  import clk_domain_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 4,
  parameter int IDLE_W = 8
) (
  input  logic                    clk_in,
  input  logic                    reset_n,
  input  logic [NUM_CH-1:0]       en_req,
  input  logic [NUM_CH*DIV_W-1:0] div_sel,
  input  logic [NUM_CH-1:0]       div_load,
  input  logic [NUM_CH-1:0]       busy,
  input  logic [IDLE_W-1:0]       idle_limit,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       en_ack,
  output logic [NUM_CH-1:0]       clk_running
);

  // One fully independent channel per bit
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
      clk_div_chan #(
        .DIV_W (DIV_W),
        .IDLE_W(IDLE_W)
      ) u_chan (
        .clk_in     (clk_in),
        .reset_n    (reset_n),
        .en_req     (en_req[gi]),
        .div_sel    (div_sel[gi*DIV_W +: DIV_W]),
        .div_load   (div_load[gi]),
        .busy       (busy[gi]),
        .idle_limit (idle_limit),
        .clk_out    (clk_out[gi]),
        .en_ack     (en_ack[gi]),
        .clk_running(clk_running[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_clock_domain_ctrl.sv
// tb_clock_domain_ctrl: scoreboard bench. Expected per-cycle output vectors
// are queued when stimulus is driven and compared at the negedge of the
// cycle they belong to.
module tb_clock_domain_ctrl;

  logic        clk_in = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  en_req = '0;
  logic [3:0]  div_load = '0;
  logic [3:0]  busy = '0;
  logic [15:0] div_sel = '0;
  logic [7:0]  idle_limit = '0;
  logic [3:0]  clk_out, en_ack, clk_running;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int t0, t1, t2;

  typedef struct {
    string      tag;
    int         cyc;
    logic [3:0] mask;
    logic [3:0] clk;
    logic [3:0] ack;
    logic [3:0] run;
  } exp_t;

  exp_t sb[$];
  exp_t cur;

  clock_domain_ctrl #(.NUM_CH(4), .DIV_W(4), .IDLE_W(8)) dut (
    .clk_in     (clk_in),
    .reset_n    (reset_n),
    .en_req     (en_req),
    .div_sel    (div_sel),
    .div_load   (div_load),
    .busy       (busy),
    .idle_limit (idle_limit),
    .clk_out    (clk_out),
    .en_ack     (en_ack),
    .clk_running(clk_running)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_at(input string tag, input int c, input logic [3:0] m,
                           input logic [3:0] k, input logic [3:0] a, input logic [3:0] r);
    exp_t e;
    e.tag = tag; e.cyc = c; e.mask = m; e.clk = k; e.ack = a; e.run = r;
    sb.push_back(e);
  endtask

  task automatic step_to(input int t);
    while (cyc < t) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() > 0 && n < budget) begin
      @(posedge clk_in);
      #1;
      n++;
    end
    check_val("drain_timeout", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  // Scoreboard: compare queued expectations at the middle of their cycle
  always @(negedge clk_in) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      cur = sb.pop_front();
      if (cur.cyc != cyc) begin
        check_val({cur.tag, "_missed"}, 32'(cyc), 32'(cur.cyc));
      end else begin
        check_val({cur.tag, "_clk"}, 32'(clk_out & cur.mask),     32'(cur.clk & cur.mask));
        check_val({cur.tag, "_ack"}, 32'(en_ack & cur.mask),      32'(cur.ack & cur.mask));
        check_val({cur.tag, "_run"}, 32'(clk_running & cur.mask), 32'(cur.run & cur.mask));
        $display("txn %s cyc=%0d clk_out=%b en_ack=%b clk_running=%b", cur.tag, cyc,
                 clk_out, en_ack, clk_running);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d expected_end_before=%0d", cyc, 20000);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held, then released with no enable: everything stays off
    expect_at("reset", 1, 4'hF, 4'h0, 4'h0, 4'h0);
    expect_at("reset", 2, 4'hF, 4'h0, 4'h0, 4'h0);
    step_to(2);
    reset_n = 1'b1;
    for (int c = 3; c <= 5; c++) expect_at("post_rst", c, 4'hF, 4'h0, 4'h0, 4'h0);
    drain(20);

    // D=0 on channel 0: period 2, grant on first rising edge
    t0 = cyc;
    en_req = 4'b0001;
    expect_at("d0_start", t0 + 1, 4'hF, 4'h0, 4'h0, 4'h0);
    for (int j = 0; j <= 8; j++)
      expect_at("d0_run", t0 + 2 + j, 4'hF, (j % 2 == 0) ? 4'b0001 : 4'b0000, 4'b0001, 4'b0001);
    expect_at("d0_off", t0 + 11, 4'hF, 4'h0, 4'h0, 4'h0);
    expect_at("d0_off", t0 + 12, 4'hF, 4'h0, 4'h0, 4'h0);
    step_to(t0 + 9);
    en_req = 4'b0000;
    drain(40);

    // D=2 on channel 1, load together with enable; truncated low-phase stop,
    // re-request during STOPPING, then a stop that finishes a high phase
    t0 = cyc;
    div_sel[7:4] = 4'd2;
    div_load = 4'b0010;
    en_req = 4'b0010;
    for (int c = 1; c <= 13; c++) begin
      if (c >= 4)
        expect_at("d2_run", t0 + c, 4'hF, (((c - 4) % 6) < 3) ? 4'b0010 : 4'b0000, 4'b0010, 4'b0010);
      else
        expect_at("d2_start", t0 + c, 4'hF, 4'h0, 4'h0, 4'h0);
    end
    expect_at("d2_stop_lo", t0 + 14, 4'hF, 4'h0, 4'b0010, 4'b0010);
    for (int c = 15; c <= 18; c++) expect_at("d2_restart_wait", t0 + c, 4'hF, 4'h0, 4'h0, 4'h0);
    expect_at("d2_restart", t0 + 19, 4'hF, 4'b0010, 4'b0010, 4'b0010);
    expect_at("d2_stop_hi", t0 + 20, 4'hF, 4'b0010, 4'b0010, 4'b0010);
    expect_at("d2_stop_hi", t0 + 21, 4'hF, 4'b0010, 4'b0010, 4'b0010);
    for (int c = 22; c <= 24; c++) expect_at("d2_off", t0 + c, 4'hF, 4'h0, 4'h0, 4'h0);
    step_to(t0 + 1);
    div_load = 4'b0000;
    step_to(t0 + 13);
    en_req = 4'b0000;
    step_to(t0 + 14);
    en_req = 4'b0010;
    step_to(t0 + 19);
    en_req = 4'b0000;
    drain(60);

    // D=3 on channel 2 loaded while OFF; en_req drops one cycle into high
    t0 = cyc;
    div_sel[11:8] = 4'd3;
    div_load = 4'b0100;
    for (int c = 1; c <= 5; c++) expect_at("d3_start", t0 + c, 4'hF, 4'h0, 4'h0, 4'h0);
    for (int c = 6; c <= 9; c++) expect_at("d3_high", t0 + c, 4'hF, 4'b0100, 4'b0100, 4'b0100);
    for (int c = 10; c <= 14; c++) expect_at("d3_off", t0 + c, 4'hF, 4'h0, 4'h0, 4'h0);
    step_to(t0 + 1);
    div_load = 4'b0000;
    en_req = 4'b0100;
    step_to(t0 + 6);
    en_req = 4'b0000;
    drain(40);

    // D=1 on channel 3, two loads while running (7 then 5): last one wins
    // and lands on the next falling edge
    t0 = cyc;
    div_sel[15:12] = 4'd1;
    div_load = 4'b1000;
    en_req = 4'b1000;
    for (int c = 1; c <= 32; c++) begin
      if (c < 3)
        expect_at("rediv_start", t0 + c, 4'hF, 4'h0, 4'h0, 4'h0);
      else if (c <= 8)
        expect_at("rediv_d1", t0 + c, 4'hF, (((c - 3) % 4) < 2) ? 4'b1000 : 4'b0000, 4'b1000, 4'b1000);
      else
        expect_at("rediv_d5", t0 + c, 4'hF, (((c - 9) % 12) >= 6) ? 4'b1000 : 4'b0000, 4'b1000, 4'b1000);
    end
    expect_at("rediv_off", t0 + 33, 4'hF, 4'h0, 4'h0, 4'h0);
    expect_at("rediv_off", t0 + 34, 4'hF, 4'h0, 4'h0, 4'h0);
    step_to(t0 + 1);
    div_load = 4'b0000;
    step_to(t0 + 5);
    div_sel[15:12] = 4'd7;
    div_load = 4'b1000;
    step_to(t0 + 6);
    div_load = 4'b0000;
    step_to(t0 + 7);
    div_sel[15:12] = 4'd5;
    div_load = 4'b1000;
    step_to(t0 + 8);
    div_load = 4'b0000;
    step_to(t0 + 28);
    en_req = 4'b0000;
    drain(60);

    // All four channels at D=3, reset pulsed mid-high; D returns to 0
    t0 = cyc;
    div_sel = 16'h3333;
    div_load = 4'b1111;
    en_req = 4'b1111;
    for (int c = 1; c <= 4; c++) expect_at("all_start", t0 + c, 4'hF, 4'h0, 4'h0, 4'h0);
    expect_at("all_high", t0 + 5, 4'hF, 4'hF, 4'hF, 4'hF);
    for (int c = 6; c <= 15; c++) expect_at("all_reset", t0 + c, 4'hF, 4'h0, 4'h0, 4'h0);
    expect_at("post_rst_d0", t0 + 16, 4'hF, 4'b0001, 4'b0001, 4'b0001);
    expect_at("post_rst_d0", t0 + 17, 4'hF, 4'b0000, 4'b0001, 4'b0001);
    expect_at("post_rst_d0", t0 + 18, 4'hF, 4'b0001, 4'b0001, 4'b0001);
    expect_at("post_rst_off", t0 + 19, 4'hF, 4'h0, 4'h0, 4'h0);
    expect_at("post_rst_off", t0 + 20, 4'hF, 4'h0, 4'h0, 4'h0);
    step_to(t0 + 1);
    div_load = 4'b0000;
    step_to(t0 + 6);
    reset_n = 1'b0;
    en_req = 4'b0000;
    step_to(t0 + 9);
    reset_n = 1'b1;
    step_to(t0 + 14);
    en_req = 4'b0001;
    step_to(t0 + 17);
    en_req = 4'b0000;
    drain(40);

`ifdef CLK_DOMAIN_AUTO_GATE_EN
    // Idle auto-gate on channel 0 at D=1, restart by busy, then stop
    t0 = cyc;
    idle_limit = 8'd8;
    busy = 4'b0000;
    div_sel[3:0] = 4'd1;
    div_load = 4'b0001;
    en_req = 4'b0001;
    expect_at("ag_start", t0 + 1, 4'hF, 4'h0, 4'h0, 4'h0);
    expect_at("ag_start", t0 + 2, 4'hF, 4'h0, 4'h0, 4'h0);
    for (int c = 3; c <= 10; c++)
      expect_at("ag_run", t0 + c, 4'hF, (((c - 3) % 4) < 2) ? 4'b0001 : 4'b0000, 4'b0001, 4'b0001);
    for (int c = 14; c <= 19; c++) expect_at("ag_gated", t0 + c, 4'hF, 4'h0, 4'b0001, 4'h0);
    expect_at("ag_restart", t0 + 20, 4'hF, 4'b0001, 4'b0001, 4'b0001);
    expect_at("ag_stop", t0 + 21, 4'hF, 4'b0001, 4'b0001, 4'b0001);
    expect_at("ag_off", t0 + 22, 4'hF, 4'h0, 4'h0, 4'h0);
    step_to(t0 + 1);
    div_load = 4'b0000;
    step_to(t0 + 17);
    busy = 4'b0001;
    step_to(t0 + 20);
    busy = 4'b0000;
    en_req = 4'b0000;
    drain(60);

    // Gated channel released by dropping en_req
    t1 = cyc;
    en_req = 4'b0001;
    expect_at("ag2_gated", t1 + 16, 4'hF, 4'h0, 4'b0001, 4'h0);
    expect_at("ag2_off", t1 + 17, 4'hF, 4'h0, 4'h0, 4'h0);
    step_to(t1 + 16);
    en_req = 4'b0000;
    drain(40);

    // idle_limit=0 never gates
    t2 = cyc;
    idle_limit = 8'd0;
    en_req = 4'b0001;
    expect_at("ag_dis_run", t2 + 24, 4'hF, 4'b0001, 4'b0001, 4'b0001);
    expect_at("ag_dis_off", t2 + 25, 4'hF, 4'h0, 4'h0, 4'h0);
    step_to(t2 + 24);
    en_req = 4'b0000;
    drain(60);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
